clock_ctrl: RTL
===============

Name: clock_ctrl

Overview:
Sequencing controller for the digital-clock datapath. It converts a 1 Hz tick and debounced user keys into per-digit command strobes (keep/add/sub/reset/clear) for the six time digits and four alarm digits. It runs the RUN / SET_TIME / SET_ALARM mode machine, selects the displayed source (tm_sac), and drives alarm ringing (beep_on, stop). It sits between the key/tick front end and datapath_clock.

Parameters:
RING_SEC, 60, ticks the alarm rings before an automatic stop pulse
DW, 4, BCD digit width

Ports:
sysclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_1hz  in  1  one-cycle pulse per second
key_mode, key_sel, key_up, key_down, key_stop  in  1 each  debounced one-cycle key pulses
num6..num1  in  4 each  current time digits (HH:MM:SS; num6 = hour tens)
alarm_num6..alarm_num3  in  4 each  current alarm digits (HH:MM)
alarm_hit  in  1  datapath alarm-match latch (l0)
keep, add, sub, clear  out  6 each  time digit strobes, bit5 = num6
reset  out  30  per-digit load field {load, value[3:0]}, bits[29:25] = num6
alarm_keep, alarm_add, alarm_sub, alarm_clear  out  4 each  alarm digit strobes, bit3 = alarm_num6
alarm_reset  out  20  alarm load fields, same format
tm_sac  out  1  1 = display time, 0 = display alarm
beep_on  out  1  ringer enable
stop  out  1  one-cycle alarm-clear pulse
mode  out  2  0 RUN, 1 SET_TIME, 2 SET_ALARM
field  out  2  selected field: 0 SS, 1 MM, 2 HH

Behaviour:
- Reset is asynchronous on rst_n. Reset values: keep and alarm_keep all ones; every other strobe and load bit 0; tm_sac 1; beep_on 0; stop 0; mode RUN; field MM; ring counter 0.
- All outputs are registered. Per digit, exactly one of keep/add/sub/clear/load is active in any cycle. Strobes last one cycle, then the digit returns to keep.
- Guard cycle:
  - The cycle after any strobe is a guard cycle, because the datapath updates one cycle late.
  - Keys arriving in a guard cycle are dropped.
  - A tick arriving in a guard cycle sets a pending flag and is served in the next cycle.
- Mode FSM:
  - key_mode steps RUN -> SET_TIME -> SET_ALARM -> RUN.
  - Entering SET_TIME sets field to MM. Entering SET_ALARM sets field to MM.
  - Key priority when several arrive in one cycle: mode > sel > up > down.
- RUN mode (on a served tick):
  - Carry chain is computed from the num inputs. num1 = 9 -> clear, else add.
  - A higher digit acts only when all lower digits wrap. Tens of SS/MM clear at 5. Hour units clear at 9.
  - 23:59:59 -> clear all six digits. Digits not acting keep.
  - In RUN, key_up/key_down/key_sel are ignored.
- SET_TIME mode:
  - Ticks are discarded, so time is frozen. key_sel cycles SS -> MM -> HH -> SS.
  - key_up/key_down load both digits of the field with the wrapped value in one cycle, using the reset load field.
  - Wrap: SS and MM 59 -> 00 and 00 -> 59; HH 23 -> 00 and 00 -> 23. There is no carry into other fields.
- SET_ALARM mode:
  - key_sel cycles MM <-> HH only. Up/down apply to the alarm digits with the same wrap rules. Time keeps running on ticks.
  - Key strobes and tick strobes never coincide: the tick is served first and the key is dropped (guard rule).
- tm_sac is 0 in SET_ALARM, otherwise 1. Its registered value updates one cycle after the mode change.
- Ringing:
  - A rising edge of alarm_hit in RUN sets beep_on = 1 and clears the ring counter.
  - Each served tick increments the counter. At RING_SEC, or on key_stop, stop pulses for one cycle and beep_on drops in the same cycle.
  - key_stop while not ringing still pulses stop.
  - alarm_hit in a SET mode does not start ringing.
- Reset mid-operation aborts any pending strobe and the guard cycle. No partial load is issued after reset.

Decomposition:
- Shared package/include holds:
  - mode encodings (RUN/SET_TIME/SET_ALARM);
  - field encodings (SS/MM/HH);
  - BCD limit constants (9, 5, 23, 59);
  - the load-field layout (load bit index 4).
- One sub-module, bcd_field_step: a combinational wrap-aware +1/-1 on a two-digit BCD field with a max parameter (59 or 23). It returns the new tens and units.

Test Plan:
- Time 23:59:59, RUN, one tick -> next cycle clear = 6'b111111; after the update, num = 00:00:00; next tick -> add[0] only.
- SET_TIME, field MM, time 12:59:30, key_up -> reset[19] and reset[14] load 0 and 0; time becomes 12:00:30; HH is unchanged.
- SET_ALARM, field HH, alarm 00:15, key_down -> alarm load 2 and 3; alarm becomes 23:15; tm_sac = 0 throughout.
- alarm_hit rises in RUN -> beep_on = 1; after 60 served ticks, stop pulses once and beep_on = 0. Repeat with key_stop at tick 5 -> stop at that cycle.
- Tick and key_up in the same cycle in SET_ALARM -> tick strobe is issued and the key is dropped. Tick during a guard cycle -> its strobe is delayed by exactly one cycle.
- rst_n pulsed while in SET_TIME with key_up pending -> mode RUN, field MM, all keep, no load emitted after release.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared encodings and constants for the clock sequencing controller.
// Load fields are {load, value[3:0]}, one per digit.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_TIME  = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    FLD_SS = 2'd0,
    FLD_MM = 2'd1,
    FLD_HH = 2'd2
  } field_e;

  localparam int BCD_9  = 9;
  localparam int BCD_5  = 5;
  localparam int MAX_HH = 23;
  localparam int MAX_MS = 59;

  localparam int LOAD_BIT = 4;
  localparam int LOAD_W   = LOAD_BIT + 1;

  function automatic logic [LOAD_W-1:0] load_field(input logic [LOAD_BIT-1:0] v);
    return {1'b1, v};
  endfunction

endpackage

// File: rtl/clock_ctrl_bcd_field_step.sv
// Wrap-aware +1/-1 on a two-digit BCD field (00..MAX).
module bcd_field_step
  import clock_ctrl_pkg::*;
#(
  parameter int DW  = 4,
  parameter int MAX = 59
) (
  input  logic [DW-1:0] tens,
  input  logic [DW-1:0] units,
  input  logic          up,
  output logic [DW-1:0] tens_n,
  output logic [DW-1:0] units_n
);

  localparam logic [DW-1:0] MAX_T = DW'(MAX / 10);
  localparam logic [DW-1:0] MAX_U = DW'(MAX % 10);
  localparam logic [DW-1:0] NINE  = DW'(BCD_9);

  always_comb begin
    tens_n  = tens;
    units_n = units;
    if (up) begin
      if (tens == MAX_T && units == MAX_U) begin
        tens_n  = '0;
        units_n = '0;
      end else if (units == NINE) begin
        tens_n  = tens + 1'b1;
        units_n = '0;
      end else begin
        units_n = units + 1'b1;
      end
    end else begin
      if (tens == '0 && units == '0) begin
        tens_n  = MAX_T;
        units_n = MAX_U;
      end else if (units == '0) begin
        tens_n  = tens - 1'b1;
        units_n = NINE;
      end else begin
        units_n = units - 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Mode/strobe sequencer between the key+tick front end and datapath_clock.
//   state      | meaning
//   MODE_RUN   | time advances on ticks, alarm may ring
//   MODE_TIME  | time frozen, up/down load the selected time field
//   MODE_ALARM | time runs, up/down load the selected alarm field
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int RING_SEC = 60,
  parameter int DW       = 4
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          tick_1hz,
  input  logic          key_mode,
  input  logic          key_sel,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_stop,
  input  logic [DW-1:0] num6,
  input  logic [DW-1:0] num5,
  input  logic [DW-1:0] num4,
  input  logic [DW-1:0] num3,
  input  logic [DW-1:0] num2,
  input  logic [DW-1:0] num1,
  input  logic [DW-1:0] alarm_num6,
  input  logic [DW-1:0] alarm_num5,
  input  logic [DW-1:0] alarm_num4,
  input  logic [DW-1:0] alarm_num3,
  input  logic          alarm_hit,
  output logic [5:0]    keep,
  output logic [5:0]    add,
  output logic [5:0]    sub,
  output logic [5:0]    clear,
  output logic [29:0]   reset,
  output logic [3:0]    alarm_keep,
  output logic [3:0]    alarm_add,
  output logic [3:0]    alarm_sub,
  output logic [3:0]    alarm_clear,
  output logic [19:0]   alarm_reset,
  output logic          tm_sac,
  output logic          beep_on,
  output logic          stop,
  output logic [1:0]    mode,
  output logic [1:0]    field
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [DW-1:0] D9 = DW'(BCD_9);
  localparam logic [DW-1:0] D5 = DW'(BCD_5);

  mode_e          mode_q;
  field_e         field_q;
  logic [5:0]     keep_q, add_q, clr_q;
  logic [29:0]    load_q;
  logic [3:0]     alm_keep_q;
  logic [19:0]    alm_load_q;
  logic           tm_sac_q, beep_q, stop_q;
  logic           guard_q, pend_q, hit_q;
  logic [RW-1:0]  ring_cnt;

  // Carry chain for a served tick, straight from the current digits.
  logic w_su, w_st, w_mu, w_mt, h_23, h_wrap;
  logic c1, c2, c3, c4;
  logic [5:0] run_add, run_clr;

  assign w_su   = (num1 == D9);
  assign w_st   = (num2 == D5);
  assign w_mu   = (num3 == D9);
  assign w_mt   = (num4 == D5);
  assign h_23   = (num6 == DW'(MAX_HH / 10)) && (num5 == DW'(MAX_HH % 10));
  assign h_wrap = h_23 || (num5 == D9);
  assign c1 = w_su;
  assign c2 = c1 & w_st;
  assign c3 = c2 & w_mu;
  assign c4 = c3 & w_mt;

  assign run_clr = {c4 & h_23,            c4 & h_wrap,  c3 & w_mt,  c2 & w_mu,  c1 & w_st,  w_su};
  assign run_add = {c4 & h_wrap & ~h_23,  c4 & ~h_wrap, c3 & ~w_mt, c2 & ~w_mu, c1 & ~w_st, ~w_su};

  logic [DW-1:0] ss_t_n, ss_u_n, mm_t_n, mm_u_n, hh_t_n, hh_u_n;
  logic [DW-1:0] am_t_n, am_u_n, ah_t_n, ah_u_n;

  bcd_field_step #(.DW(DW), .MAX(MAX_MS)) u_step_ss (
    .tens(num2), .units(num1), .up(key_up), .tens_n(ss_t_n), .units_n(ss_u_n));
  bcd_field_step #(.DW(DW), .MAX(MAX_MS)) u_step_mm (
    .tens(num4), .units(num3), .up(key_up), .tens_n(mm_t_n), .units_n(mm_u_n));
  bcd_field_step #(.DW(DW), .MAX(MAX_HH)) u_step_hh (
    .tens(num6), .units(num5), .up(key_up), .tens_n(hh_t_n), .units_n(hh_u_n));
  bcd_field_step #(.DW(DW), .MAX(MAX_MS)) u_step_am (
    .tens(alarm_num4), .units(alarm_num3), .up(key_up), .tens_n(am_t_n), .units_n(am_u_n));
  bcd_field_step #(.DW(DW), .MAX(MAX_HH)) u_step_ah (
    .tens(alarm_num6), .units(alarm_num5), .up(key_up), .tens_n(ah_t_n), .units_n(ah_u_n));

  logic [29:0] set_load;
  logic [5:0]  set_mask;
  logic [19:0] alm_load;
  logic [3:0]  alm_mask;

  always_comb begin
    set_load = '0;
    set_mask = '0;
    case (field_q)
      FLD_SS: begin
        set_load[9:0] = {load_field(ss_t_n), load_field(ss_u_n)};
        set_mask      = 6'b000011;
      end
      FLD_MM: begin
        set_load[19:10] = {load_field(mm_t_n), load_field(mm_u_n)};
        set_mask        = 6'b001100;
      end
      FLD_HH: begin
        set_load[29:20] = {load_field(hh_t_n), load_field(hh_u_n)};
        set_mask        = 6'b110000;
      end
      default: ;
    endcase
  end

  always_comb begin
    alm_load = '0;
    alm_mask = '0;
    case (field_q)
      FLD_MM: begin
        alm_load[9:0] = {load_field(am_t_n), load_field(am_u_n)};
        alm_mask      = 4'b0011;
      end
      FLD_HH: begin
        alm_load[19:10] = {load_field(ah_t_n), load_field(ah_u_n)};
        alm_mask        = 4'b1100;
      end
      default: ;
    endcase
  end

  // Ticks are never served while the datapath is still absorbing a strobe.
  logic tick_srv;
  assign tick_srv = !guard_q && (tick_1hz || pend_q) && (mode_q != MODE_TIME);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_RUN;
      field_q    <= FLD_MM;
      keep_q     <= '1;
      add_q      <= '0;
      clr_q      <= '0;
      load_q     <= '0;
      alm_keep_q <= '1;
      alm_load_q <= '0;
      tm_sac_q   <= 1'b1;
      beep_q     <= 1'b0;
      stop_q     <= 1'b0;
      guard_q    <= 1'b0;
      pend_q     <= 1'b0;
      hit_q      <= 1'b0;
      ring_cnt   <= '0;
    end else begin
      keep_q     <= '1;
      add_q      <= '0;
      clr_q      <= '0;
      load_q     <= '0;
      alm_keep_q <= '1;
      alm_load_q <= '0;
      stop_q     <= 1'b0;
      guard_q    <= 1'b0;
      hit_q      <= alarm_hit;
      tm_sac_q   <= (mode_q != MODE_ALARM);

      if (guard_q) begin
        if (tick_1hz && mode_q != MODE_TIME) pend_q <= 1'b1;
      end else begin
        pend_q <= 1'b0;
        if (tick_srv) begin
          add_q   <= run_add;
          clr_q   <= run_clr;
          keep_q  <= ~(run_add | run_clr);
          guard_q <= 1'b1;
        end else if (key_mode) begin
          case (mode_q)
            MODE_RUN:  begin mode_q <= MODE_TIME;  field_q <= FLD_MM; end
            MODE_TIME: begin mode_q <= MODE_ALARM; field_q <= FLD_MM; end
            default:   mode_q <= MODE_RUN;
          endcase
        end else if (key_sel) begin
          if (mode_q == MODE_TIME) begin
            case (field_q)
              FLD_SS:  field_q <= FLD_MM;
              FLD_MM:  field_q <= FLD_HH;
              default: field_q <= FLD_SS;
            endcase
          end else if (mode_q == MODE_ALARM) begin
            field_q <= (field_q == FLD_HH) ? FLD_MM : FLD_HH;
          end
        end else if (key_up || key_down) begin
          if (mode_q == MODE_TIME) begin
            load_q  <= set_load;
            keep_q  <= ~set_mask;
            guard_q <= |set_mask;
          end else if (mode_q == MODE_ALARM) begin
            alm_load_q <= alm_load;
            alm_keep_q <= ~alm_mask;
            guard_q    <= |alm_mask;
          end
        end
      end

      if (key_stop || (beep_q && tick_srv && ring_cnt == RW'(RING_SEC - 1))) begin
        stop_q <= 1'b1;
        beep_q <= 1'b0;
      end else if (alarm_hit && !hit_q && mode_q == MODE_RUN) begin
        beep_q   <= 1'b1;
        ring_cnt <= '0;
      end else if (beep_q && tick_srv) begin
        ring_cnt <= ring_cnt + 1'b1;
      end
    end
  end

  assign keep        = keep_q;
  assign add         = add_q;
  assign sub         = '0;
  assign clear       = clr_q;
  assign reset       = load_q;
  assign alarm_keep  = alm_keep_q;
  assign alarm_add   = '0;
  assign alarm_sub   = '0;
  assign alarm_clear = '0;
  assign alarm_reset = alm_load_q;
  assign tm_sac      = tm_sac_q;
  assign beep_on     = beep_q;
  assign stop        = stop_q;
  assign mode        = mode_q;
  assign field       = field_q;

endmodule
